pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Sequencing controller for the five-step pipeline. Resolves control-flow redirects from step 4, detects load-use hazards between steps 2 and 3, and drives PC select, the PC/step-1 register enables and the squash strobes for steps 1–3. Holds the front end idle for a programmable number of cycles after reset and keeps saturating redirect and stall counters for debug.

## Interface
- RESET_HOLD, default 2: cycles after reset release during which fetch is held and steps 1–3 are squashed; legal range 1–15.
- CNT_W, default 16: width of the performance counters.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- opcode_step_2  in  6  opcode of the instruction in step 2.
- rs_step_2  in  5  rs field in step 2.
- rt_step_2  in  5  rt field in step 2.
- opcode_step_3  in  6  opcode in step 3.
- rt_step_3  in  5  rt field in step 3 (lw destination).
- opcode_step_4  in  6  opcode in step 4.
- is_alu_zero_step_4  in  1  ALU zero flag in step 4.
- control_mux_for_PC  out  2  00 = PC+4, 01 = branch target, 10 = jump target; 11 is never driven.
- pc_en  out  1  PC register load enable.
- step_1_en  out  1  step-1 pipeline register enable.
- flush_step_1, flush_step_2, flush_step_3  out  1 each  load a nop into that step's register on the next edge.
- redirect_count  out  CNT_W  number of taken redirects, saturating.
- stall_count  out  CNT_W  number of load-use stall cycles, saturating.

## Operation
- Opcodes: R-type 000000, j 000010, beq 000100, addi 001000, lw 100011, sw 101011.
- redirect = (opcode_step_4 == beq && is_alu_zero_step_4) || opcode_step_4 == j.
- load_use = opcode_step_3 == lw && rt_step_3 != 0 && (rt_step_3 == rs_step_2 || (rt_step_3 == rt_step_2 && opcode_step_2 ∈ {R-type, beq, sw})).
- States: HOLD, RUN, STALL. Reset enters HOLD with the hold counter at 0.
- HOLD: pc_en = 0, step_1_en = 0, all flushes = 1, mux = 00. The hold counter increments each cycle. Transition to RUN when the counter reaches RESET_HOLD−1.
- RUN with redirect: mux = 01 for beq or 10 for j; pc_en = 1; step_1_en = 1; flush_step_1/2/3 = 1. Next state is RUN and redirect_count increments. Redirect has priority over load_use; the stall is suppressed and stall_count is unchanged.
- RUN with load_use and no redirect: pc_en = 0, step_1_en = 0, flush_step_3 = 1, mux = 00. Next state is STALL and stall_count increments.
- RUN otherwise: pc_en = 1, step_1_en = 1, no flushes, mux = 00.
- STALL: load_use is ignored, so at most one consecutive stall cycle occurs. Redirect is still honoured exactly as in RUN. Outputs otherwise match the RUN-idle case. Next state is RUN.
- Counters saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from state and step inputs within the same cycle. There is no added latency, so the redirect takes effect on the edge ending the cycle in which the beq or j sits in step 4.
- Counters and state are registered and update on the same edge as the PC.
- Reset values (asserted immediately, asynchronously): state HOLD, hold counter 0, both counters 0. Outputs: mux 00, pc_en 0, step_1_en 0, flush_step_1/2/3 = 1.
- Reset asserted mid-stall or mid-redirect aborts the operation with no partial counter update. After release, exactly RESET_HOLD HOLD cycles occur before the first fetch.

## Structure
- Opcode localparams, mux encodings and state encodings go in the shared cpu_defs.vh include, which is also used by the decode and step-4 logic.
- One sub-module is natural: sat_counter, parameterised by width, with inc and async active-low clear. It is instantiated twice.
- Hazard comparison and the FSM stay inline.

## Test plan
- Reset release with RESET_HOLD = 2 -> pc_en = 0 and flushes = 1 for exactly 2 cycles, then pc_en = 1 with mux 00.
- beq in step 4 with zero = 1 -> mux 01, flush_step_1/2/3 = 1, redirect_count goes 0→1. The same with zero = 0 -> mux 00, no flush, count unchanged.
- lw rt = 5 in step 3 and add with rs = 5 in step 2 -> one cycle of pc_en = 0, step_1_en = 0, flush_step_3 = 1, stall_count = 1. Next cycle pc_en = 1.
- lw rt = 0, or an addi whose rt matches the lw rt -> no stall.
- j in step 4 and load_use in the same cycle -> mux 10, all flushes, no stall, stall_count unchanged.
- Force 2^CNT_W+3 redirects -> redirect_count holds at all-ones. Assert rst mid-stall -> outputs return to reset values immediately and counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared opcode, PC-select and state encodings for the pipeline sequencing logic.
package pipeline_hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10
    } state_e;

    // Opcodes whose rt field is a source operand (not a destination).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; async active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end sequencing: post-reset hold, step-4 redirects, step-2/3 load-use stalls,
// plus saturating debug counters for redirects and stall cycles.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RESET_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode_step_2,
    input  logic [4:0]       rs_step_2,
    input  logic [4:0]       rt_step_2,
    input  logic [5:0]       opcode_step_3,
    input  logic [4:0]       rt_step_3,
    input  logic [5:0]       opcode_step_4,
    input  logic             is_alu_zero_step_4,
    output logic [1:0]       control_mux_for_PC,
    output logic             pc_en,
    output logic             step_1_en,
    output logic             flush_step_1,
    output logic             flush_step_2,
    output logic             flush_step_3,
    output logic [CNT_W-1:0] redirect_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

    state_e     state, state_nxt;
    logic [3:0] hold_cnt;
    logic       redirect, load_use;
    logic       redirect_inc, stall_inc;

    assign redirect = ((opcode_step_4 == OP_BEQ) && is_alu_zero_step_4) || (opcode_step_4 == OP_J);
    assign load_use = (opcode_step_3 == OP_LW) && (rt_step_3 != 5'd0) &&
                      ((rt_step_3 == rs_step_2) || ((rt_step_3 == rt_step_2) && reads_rt(opcode_step_2)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_HOLD;
            hold_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_HOLD && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt          = ST_HOLD;
        control_mux_for_PC = PC_SEL_SEQ;
        pc_en              = 1'b0;
        step_1_en          = 1'b0;
        flush_step_1       = 1'b1;
        flush_step_2       = 1'b1;
        flush_step_3       = 1'b1;
        redirect_inc       = 1'b0;
        stall_inc          = 1'b0;
        case (state)
            ST_HOLD: begin
                state_nxt = (hold_cnt == HOLD_LAST) ? ST_RUN : ST_HOLD;
            end
            ST_RUN, ST_STALL: begin
                state_nxt    = ST_RUN;
                pc_en        = 1'b1;
                step_1_en    = 1'b1;
                flush_step_1 = 1'b0;
                flush_step_2 = 1'b0;
                flush_step_3 = 1'b0;
                if (redirect) begin
                    control_mux_for_PC = (opcode_step_4 == OP_J) ? PC_SEL_JUMP : PC_SEL_BRANCH;
                    flush_step_1       = 1'b1;
                    flush_step_2       = 1'b1;
                    flush_step_3       = 1'b1;
                    redirect_inc       = 1'b1;
                end else if (load_use && state == ST_RUN) begin
                    // Only from RUN, so a stall never repeats back-to-back.
                    state_nxt    = ST_STALL;
                    pc_en        = 1'b0;
                    step_1_en    = 1'b0;
                    flush_step_3 = 1'b1;
                    stall_inc    = 1'b1;
                end
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (redirect_inc),
        .count (redirect_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (stall_inc),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table, hand-written reset/saturation sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int RESET_HOLD = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011;

    // {mux[1:0], pc_en, step_1_en, flush_3, flush_2, flush_1}
    localparam logic [6:0] C_HOLD = 7'b00_0_0_111;
    localparam logic [6:0] C_IDLE = 7'b00_1_1_000;
    localparam logic [6:0] C_BR   = 7'b01_1_1_111;
    localparam logic [6:0] C_JMP  = 7'b10_1_1_111;
    localparam logic [6:0] C_STL  = 7'b00_0_0_100;

    logic             clk, rst;
    logic [5:0]       opcode_step_2, opcode_step_3, opcode_step_4;
    logic [4:0]       rs_step_2, rt_step_2, rt_step_3;
    logic             is_alu_zero_step_4;
    logic [1:0]       control_mux_for_PC;
    logic             pc_en, step_1_en, flush_step_1, flush_step_2, flush_step_3;
    logic [CNT_W-1:0] redirect_count, stall_count;

    pipeline_hazard_ctrl #(.RESET_HOLD(RESET_HOLD), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode_step_2      (opcode_step_2),
        .rs_step_2          (rs_step_2),
        .rt_step_2          (rt_step_2),
        .opcode_step_3      (opcode_step_3),
        .rt_step_3          (rt_step_3),
        .opcode_step_4      (opcode_step_4),
        .is_alu_zero_step_4 (is_alu_zero_step_4),
        .control_mux_for_PC (control_mux_for_PC),
        .pc_en              (pc_en),
        .step_1_en          (step_1_en),
        .flush_step_1       (flush_step_1),
        .flush_step_2       (flush_step_2),
        .flush_step_3       (flush_step_3),
        .redirect_count     (redirect_count),
        .stall_count        (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0] op2; logic [4:0] rs2; logic [4:0] rt2;
        logic [5:0] op3; logic [4:0] rt3;
        logic [5:0] op4; logic       z4;
        logic [6:0] ctl; int rc; int sc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {control_mux_for_PC, pc_en, step_1_en, flush_step_3, flush_step_2, flush_step_1};
    endfunction

    function automatic vec_t mk(input logic [5:0] op2, input int rs2, input int rt2,
                                input logic [5:0] op3, input int rt3,
                                input logic [5:0] op4, input logic z4,
                                input logic [6:0] ctl, input int rc, input int sc);
        vec_t v;
        v.op2 = op2; v.rs2 = 5'(rs2); v.rt2 = 5'(rt2);
        v.op3 = op3; v.rt3 = 5'(rt3);
        v.op4 = op4; v.z4 = z4;
        v.ctl = ctl; v.rc = rc; v.sc = sc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        opcode_step_2 = v.op2; rs_step_2 = v.rs2; rt_step_2 = v.rt2;
        opcode_step_3 = v.op3; rt_step_3 = v.rt3;
        opcode_step_4 = v.op4; is_alu_zero_step_4 = v.z4;
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic apply(input vec_t v, input string name);
        drive(v);
        #1;
        chk({name, " ctl"}, 32'(ctl_now()), 32'(v.ctl));
        chk({name, " redirect_count"}, 32'(redirect_count), 32'(v.rc));
        chk({name, " stall_count"}, 32'(stall_count), 32'(v.sc));
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, " ctl"}, 32'(ctl_now()), 32'(C_HOLD));
        chk({name, " redirect_count"}, 32'(redirect_count), 32'd0);
        chk({name, " stall_count"}, 32'(stall_count), 32'd0);
    endtask

    // Behavioural model: hold cycles remaining, whether the previous cycle stalled, and counts.
    int m_hold, m_rc, m_sc;
    bit m_stalled;

    task automatic model_reset();
        m_hold = RESET_HOLD; m_stalled = 0; m_rc = 0; m_sc = 0;
    endtask

    task automatic model_cycle(output logic [6:0] ctl);
        bit redir, lu;
        redir = ((opcode_step_4 == BEQ) && is_alu_zero_step_4) || (opcode_step_4 == J);
        lu = (opcode_step_3 == LW) && (rt_step_3 != 0) &&
             ((rt_step_3 == rs_step_2) ||
              ((rt_step_3 == rt_step_2) && (opcode_step_2 == RT || opcode_step_2 == BEQ || opcode_step_2 == SW)));
        if (m_hold > 0) begin
            ctl = C_HOLD;
            m_hold--;
            m_stalled = 0;
        end else if (redir) begin
            ctl = (opcode_step_4 == J) ? C_JMP : C_BR;
            if (m_rc < CNT_MAX) m_rc++;
            m_stalled = 0;
        end else if (lu && !m_stalled) begin
            ctl = C_STL;
            if (m_sc < CNT_MAX) m_sc++;
            m_stalled = 1;
        end else begin
            ctl = C_IDLE;
            m_stalled = 0;
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [6];
        ops[0] = RT; ops[1] = J; ops[2] = BEQ; ops[3] = ADDI; ops[4] = LW; ops[5] = SW;
        return ops[$urandom_range(0, 5)];
    endfunction

    vec_t tbl [16];
    vec_t nop, jv, luv;

    initial begin
        logic [6:0] exp_ctl;
        int         exp_rc, exp_sc;

        nop = mk(RT, 0, 0, RT, 0, RT, 1'b0, C_IDLE, 0, 0);
        tbl[0]  = mk(RT,   0, 0, RT, 0, J,   1'b0, C_HOLD, 0, 0);
        tbl[1]  = mk(RT,   5, 0, LW, 5, BEQ, 1'b1, C_HOLD, 0, 0);
        tbl[2]  = mk(RT,   0, 0, RT, 0, RT,  1'b0, C_IDLE, 0, 0);
        tbl[3]  = mk(RT,   0, 0, RT, 0, BEQ, 1'b1, C_BR,   0, 0);
        tbl[4]  = mk(RT,   0, 0, RT, 0, BEQ, 1'b0, C_IDLE, 1, 0);
        tbl[5]  = mk(RT,   5, 1, LW, 5, RT,  1'b0, C_STL,  1, 0);
        tbl[6]  = mk(RT,   5, 1, LW, 5, RT,  1'b0, C_IDLE, 1, 1);
        tbl[7]  = mk(RT,   0, 0, RT, 0, RT,  1'b0, C_IDLE, 1, 1);
        tbl[8]  = mk(RT,   0, 0, LW, 0, RT,  1'b0, C_IDLE, 1, 1);
        tbl[9]  = mk(ADDI, 3, 7, LW, 7, RT,  1'b0, C_IDLE, 1, 1);
        tbl[10] = mk(SW,   2, 7, LW, 7, RT,  1'b0, C_STL,  1, 1);
        tbl[11] = mk(SW,   2, 7, LW, 7, BEQ, 1'b1, C_BR,   1, 2);
        tbl[12] = mk(RT,   7, 0, LW, 7, J,   1'b0, C_JMP,  2, 2);
        tbl[13] = mk(BEQ,  1, 9, LW, 9, RT,  1'b0, C_STL,  3, 2);
        tbl[14] = mk(RT,   0, 0, RT, 0, RT,  1'b0, C_IDLE, 3, 3);
        tbl[15] = mk(RT,   0, 0, RT, 0, RT,  1'b0, C_IDLE, 3, 3);

        rst = 1'b0;
        drive(nop);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("in_reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("row%0d", i));

        // 2^CNT_W + 3 jumps: count climbs from 3 and sticks at all-ones.
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            jv = mk(RT, 0, 0, RT, 0, J, 1'b1, C_JMP, (3 + i > CNT_MAX) ? CNT_MAX : 3 + i, 3);
            apply(jv, $sformatf("sat%0d", i));
        end
        nop.rc = CNT_MAX; nop.sc = 3;
        apply(nop, "sat_final");

        // Reset asserted while in the stall-following cycle.
        luv = mk(RT, 4, 0, LW, 4, RT, 1'b0, C_STL, CNT_MAX, 3);
        apply(luv, "pre_rst_stall");
        nop.sc = 4;
        drive(nop);
        #1;
        chk("stall_state ctl", 32'(ctl_now()), 32'(C_IDLE));
        #1 rst = 1'b0;
        #1;
        chk_reset_state("rst_mid_stall");
        @(negedge clk);
        rst = 1'b1;
        apply(mk(RT, 0, 0, RT, 0, J, 1'b0, C_HOLD, 0, 0), "post_rst_hold0");
        apply(mk(RT, 0, 0, RT, 0, J, 1'b0, C_HOLD, 0, 0), "post_rst_hold1");

        // Reset during a RUN cycle that is requesting a stall: no partial count.
        apply(mk(RT, 6, 0, LW, 6, RT, 1'b0, C_STL, 0, 0), "pre_rst_lu");
        apply(mk(RT, 0, 0, RT, 0, RT, 1'b0, C_IDLE, 0, 1), "stall_then");
        drive(mk(RT, 6, 0, LW, 6, RT, 1'b0, C_STL, 0, 1));
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("rst_in_lu_cycle");
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                chk_reset_state($sformatf("rand_rst%0d", cyc));
                @(negedge clk);
                rst = 1'b1;
                model_reset();
            end else begin
                opcode_step_2 = rand_op(); rs_step_2 = 5'($urandom_range(0, 3)); rt_step_2 = 5'($urandom_range(0, 3));
                opcode_step_3 = rand_op(); rt_step_3 = 5'($urandom_range(0, 3));
                opcode_step_4 = rand_op(); is_alu_zero_step_4 = 1'($urandom_range(0, 1));
                #1;
                exp_rc = m_rc; exp_sc = m_sc;
                model_cycle(exp_ctl);
                chk($sformatf("rand%0d ctl", cyc), 32'(ctl_now()), 32'(exp_ctl));
                chk($sformatf("rand%0d redirect_count", cyc), 32'(redirect_count), 32'(exp_rc));
                chk($sformatf("rand%0d stall_count", cyc), 32'(stall_count), 32'(exp_sc));
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
